// File: rtl/rtc_fecha_writer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rtc_pkg : shared states, write indices, month lengths, RTC addresses  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package rtc_pkg;

  typedef enum logic [2:0] {
    IDLE, CHECK, ADDR_PH, GAP_A, DATA_PH, GAP_D, FIN
  } state_t;

  typedef enum logic [1:0] {W_DIA, W_MES, W_YEAR, W_CMD} widx_t;

  localparam logic [7:0] MES_MAX       = 8'd12;
  localparam logic [7:0] YEAR_MAX      = 8'd99;
  localparam logic [7:0] MES_FEB       = 8'd2;
  localparam logic [7:0] FEB_MAX_DIA   = 8'd29;
  localparam logic [7:0] SHORT_MAX_DIA = 8'd30;
  localparam logic [7:0] LONG_MAX_DIA  = 8'd31;
  localparam logic [7:0] SHORT_MONTHS [4] = '{8'd4, 8'd6, 8'd9, 8'd11};

  // Register map shared with the RTC read sequencer
  localparam logic [7:0] RTC_ADDR_DIA  = 8'h24;
  localparam logic [7:0] RTC_ADDR_MES  = 8'h25;
  localparam logic [7:0] RTC_ADDR_YEAR = 8'h26;

  function automatic logic [7:0] max_dia(input logic [7:0] mes);
    logic [7:0] m;
    m = LONG_MAX_DIA;
    if (mes == MES_FEB) m = FEB_MAX_DIA;
    for (int i = 0; i < 4; i++)
      if (mes == SHORT_MONTHS[i]) m = SHORT_MAX_DIA;
    return m;
  endfunction

  function automatic logic fecha_valid(input logic [7:0] dia,
                                       input logic [7:0] mes,
                                       input logic [7:0] year);
    return (mes >= 8'd1) && (mes <= MES_MAX) && (year <= YEAR_MAX) &&
           (dia >= 8'd1) && (dia <= max_dia(mes));
  endfunction

endpackage
`default_nettype wire

// File: rtl/rtc_fecha_writer_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rtc_fecha_writer_if : commit handshake plus RTC multiplexed bus pins  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface rtc_fecha_writer_if;
  logic       start;
  logic [7:0] dia_in;
  logic [7:0] mes_in;
  logic [7:0] year_in;
  logic       busy;
  logic       done;
  logic       error;
  logic       cs_n;
  logic       rd_n;
  logic       wr_n;
  logic       a_d_n;
  logic [7:0] ad_out;
  logic       ad_oe;

  modport master (
    output start, dia_in, mes_in, year_in,
    input  busy, done, error, cs_n, rd_n, wr_n, a_d_n, ad_out, ad_oe
  );

  modport slave (
    input  start, dia_in, mes_in, year_in,
    output busy, done, error, cs_n, rd_n, wr_n, a_d_n, ad_out, ad_oe
  );
endinterface
`default_nettype wire

// File: rtl/rtc_fecha_writer_bin2bcd8.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bin2bcd8 : binary 0-99 to packed two-digit BCD, combinational         |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module bin2bcd8 (
  input  logic [7:0] bin,
  output logic [7:0] bcd
);
  logic [7:0] rem;
  logic [3:0] tens;

  always_comb begin
    rem  = bin;
    tens = 4'd0;
    for (int i = 0; i < 9; i++) begin
      if (rem >= 8'd10) begin
        rem  = rem - 8'd10;
        tens = tens + 4'd1;
      end
    end
    bcd = {tens, rem[3:0]};
  end
endmodule
`default_nettype wire

// File: rtl/rtc_fecha_writer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rtc_fecha_writer : validate date, convert to BCD, write it to the RTC |
// | Optional RTC_TRANSFER_CMD_EN appends a transfer-command write.        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module rtc_fecha_writer
  import rtc_pkg::*;
#(
  parameter int         T_PULSE   = 4,
  parameter int         T_GAP     = 2,
  parameter logic [7:0] ADDR_DIA  = RTC_ADDR_DIA,
  parameter logic [7:0] ADDR_MES  = RTC_ADDR_MES,
  parameter logic [7:0] ADDR_YEAR = RTC_ADDR_YEAR
`ifdef RTC_TRANSFER_CMD_EN
  ,
  parameter logic [7:0] CMD_ADDR  = 8'hF1,
  parameter logic [7:0] CMD_DATA  = 8'hF1
`endif
) (
  input  logic                clk,
  input  logic                reset,
  rtc_fecha_writer_if.slave   bus
);

  localparam int MAX_PH = (T_PULSE > T_GAP) ? T_PULSE : T_GAP;
  localparam int CW     = $clog2(MAX_PH + 1);
  localparam logic [CW-1:0] PULSE_LD = CW'(T_PULSE - 1);
  localparam logic [CW-1:0] GAP_LD   = CW'(T_GAP - 1);
`ifdef RTC_TRANSFER_CMD_EN
  localparam widx_t LAST_W = W_CMD;
`else
  localparam widx_t LAST_W = W_YEAR;
`endif

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  widx_t         widx, widx_nx;
  logic          error_q, error_nx;
  logic          load;
  logic [7:0]    dia_q, mes_q, year_q;
  logic [7:0]    dia_bcd, mes_bcd, year_bcd;
  logic [7:0]    addr_sel, data_sel;

  bin2bcd8 u_dia  (.bin(dia_q),  .bcd(dia_bcd));
  bin2bcd8 u_mes  (.bin(mes_q),  .bcd(mes_bcd));
  bin2bcd8 u_year (.bin(year_q), .bcd(year_bcd));

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      widx    <= W_DIA;
      error_q <= 1'b0;
      dia_q   <= '0;
      mes_q   <= '0;
      year_q  <= '0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      widx    <= widx_nx;
      error_q <= error_nx;
      if (load) begin
        dia_q  <= bus.dia_in;
        mes_q  <= bus.mes_in;
        year_q <= bus.year_in;
      end
    end
  end

  // Each phase counts down from its length minus one, reloading on entry
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    widx_nx  = widx;
    error_nx = 1'b0;
    load     = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          state_nx = CHECK;
          load     = 1'b1;
        end
      end
      CHECK: begin
        if (fecha_valid(dia_q, mes_q, year_q)) begin
          state_nx = ADDR_PH;
          cnt_nx   = PULSE_LD;
          widx_nx  = W_DIA;
        end else begin
          state_nx = IDLE;
          error_nx = 1'b1;
        end
      end
      ADDR_PH: begin
        if (cnt == '0) begin
          state_nx = GAP_A;
          cnt_nx   = GAP_LD;
        end else cnt_nx = cnt - CW'(1);
      end
      GAP_A: begin
        if (cnt == '0) begin
          state_nx = DATA_PH;
          cnt_nx   = PULSE_LD;
        end else cnt_nx = cnt - CW'(1);
      end
      DATA_PH: begin
        if (cnt == '0) begin
          state_nx = GAP_D;
          cnt_nx   = GAP_LD;
        end else cnt_nx = cnt - CW'(1);
      end
      GAP_D: begin
        if (cnt == '0) begin
          if (widx == LAST_W) begin
            state_nx = FIN;
          end else begin
            state_nx = ADDR_PH;
            cnt_nx   = PULSE_LD;
            widx_nx  = widx_t'(widx + 2'd1);
          end
        end else cnt_nx = cnt - CW'(1);
      end
      FIN:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    addr_sel = ADDR_DIA;
    data_sel = dia_bcd;
    unique case (widx)
      W_DIA:  begin addr_sel = ADDR_DIA;  data_sel = dia_bcd;  end
      W_MES:  begin addr_sel = ADDR_MES;  data_sel = mes_bcd;  end
      W_YEAR: begin addr_sel = ADDR_YEAR; data_sel = year_bcd; end
`ifdef RTC_TRANSFER_CMD_EN
      W_CMD:  begin addr_sel = CMD_ADDR;  data_sel = CMD_DATA; end
`else
      W_CMD:  begin addr_sel = ADDR_YEAR; data_sel = year_bcd; end
`endif
      default: begin addr_sel = ADDR_DIA; data_sel = dia_bcd; end
    endcase
  end

  // The address stays on the bus through GAP_A, the data through GAP_D
  assign bus.busy   = (state != IDLE) && (state != FIN);
  assign bus.done   = (state == FIN);
  assign bus.error  = error_q;
  assign bus.cs_n   = !((state == ADDR_PH) || (state == DATA_PH));
  assign bus.wr_n   = !((state == ADDR_PH) || (state == DATA_PH));
  assign bus.rd_n   = 1'b1;
  assign bus.a_d_n  = !((state == ADDR_PH) || (state == GAP_A));
  assign bus.ad_oe  = (state == ADDR_PH) || (state == GAP_A) ||
                      (state == DATA_PH) || (state == GAP_D);
  assign bus.ad_out = ((state == ADDR_PH) || (state == GAP_A)) ? addr_sel :
                      ((state == DATA_PH) || (state == GAP_D)) ? data_sel : 8'h00;

endmodule
`default_nettype wire

// File: tb/tb_rtc_fecha_writer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_rtc_fecha_writer : directed self-checking bench for the RTC writer |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_rtc_fecha_writer;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   checks   = 0;
  int   failures = 0;

`ifdef RTC_TRANSFER_CMD_EN
  localparam int NW = 4;
`else
  localparam int NW = 3;
`endif
  localparam int W      = 12;
  localparam int DONE_C = 2 + NW * W;

  rtc_fecha_writer_if bus();

  rtc_fecha_writer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Start is sampled at the edge that follows; the next negedge is cycle 1
  task automatic commit(input logic [7:0] d, input logic [7:0] m, input logic [7:0] y);
    @(negedge clk);
    bus.start   = 1'b1;
    bus.dia_in  = d;
    bus.mes_in  = m;
    bus.year_in = y;
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    checks++; if (bus.error !== 1'b0) begin failures++; $display("FAIL reset_error got=%b exp=0", bus.error); end
    checks++; if (bus.cs_n !== 1'b1) begin failures++; $display("FAIL reset_cs_n got=%b exp=1", bus.cs_n); end
    checks++; if (bus.rd_n !== 1'b1) begin failures++; $display("FAIL reset_rd_n got=%b exp=1", bus.rd_n); end
    checks++; if (bus.wr_n !== 1'b1) begin failures++; $display("FAIL reset_wr_n got=%b exp=1", bus.wr_n); end
    checks++; if (bus.a_d_n !== 1'b1) begin failures++; $display("FAIL reset_a_d_n got=%b exp=1", bus.a_d_n); end
    checks++; if (bus.ad_out !== 8'h00) begin failures++; $display("FAIL reset_ad_out got=%h exp=00", bus.ad_out); end
    checks++; if (bus.ad_oe !== 1'b0) begin failures++; $display("FAIL reset_ad_oe got=%b exp=0", bus.ad_oe); end
    reset = 1'b0;
  endtask

  task automatic test_write_sequence();
    logic [7:0] exp_addr [4];
    logic [7:0] exp_data [4];
    logic       exp_cs, exp_oe, exp_busy, exp_done;
    int         p, w;
    exp_addr = '{8'h24, 8'h25, 8'h26, 8'hF1};
    exp_data = '{8'h15, 8'h03, 8'h16, 8'hF1};
    commit(8'd15, 8'd3, 8'd16);
    for (int c = 1; c <= DONE_C + 2; c++) begin
      @(negedge clk);
      p = (c - 2) % W;
      w = (c - 2) / W;
      exp_busy = (c < DONE_C);
      exp_done = (c == DONE_C);
      exp_oe   = (c >= 2) && (c < DONE_C);
      exp_cs   = !(exp_oe && ((p < 4) || (p >= 6 && p < 10)));
      checks++; if (bus.cs_n !== exp_cs) begin failures++; $display("FAIL seq_cs_n cycle=%0d got=%b exp=%b", c, bus.cs_n, exp_cs); end
      checks++; if (bus.wr_n !== exp_cs) begin failures++; $display("FAIL seq_wr_n cycle=%0d got=%b exp=%b", c, bus.wr_n, exp_cs); end
      checks++; if (bus.rd_n !== 1'b1) begin failures++; $display("FAIL seq_rd_n cycle=%0d got=%b exp=1", c, bus.rd_n); end
      checks++; if (bus.busy !== exp_busy) begin failures++; $display("FAIL seq_busy cycle=%0d got=%b exp=%b", c, bus.busy, exp_busy); end
      checks++; if (bus.done !== exp_done) begin failures++; $display("FAIL seq_done cycle=%0d got=%b exp=%b", c, bus.done, exp_done); end
      checks++; if (bus.ad_oe !== exp_oe) begin failures++; $display("FAIL seq_ad_oe cycle=%0d got=%b exp=%b", c, bus.ad_oe, exp_oe); end
      checks++; if (bus.error !== 1'b0) begin failures++; $display("FAIL seq_error cycle=%0d got=%b exp=0", c, bus.error); end
      if (exp_oe && p < 4) begin
        checks++; if (bus.a_d_n !== 1'b0) begin failures++; $display("FAIL seq_a_d_n_addr cycle=%0d got=%b exp=0", c, bus.a_d_n); end
        checks++; if (bus.ad_out !== exp_addr[w]) begin failures++; $display("FAIL seq_addr cycle=%0d got=%h exp=%h", c, bus.ad_out, exp_addr[w]); end
      end
      if (exp_oe && p >= 6 && p < 10) begin
        checks++; if (bus.a_d_n !== 1'b1) begin failures++; $display("FAIL seq_a_d_n_data cycle=%0d got=%b exp=1", c, bus.a_d_n); end
        checks++; if (bus.ad_out !== exp_data[w]) begin failures++; $display("FAIL seq_data cycle=%0d got=%h exp=%h", c, bus.ad_out, exp_data[w]); end
      end
      if (exp_done) begin
        checks++; if (bus.a_d_n !== 1'b1) begin failures++; $display("FAIL seq_fin_a_d_n got=%b exp=1", bus.a_d_n); end
      end
    end
  endtask

  task automatic test_invalid();
    logic [7:0] vd [8];
    logic [7:0] vm [8];
    logic [7:0] vy [8];
    vd = '{8'd31, 8'd30, 8'd0,  8'd5,  8'd5,   8'd32, 8'd31, 8'd1};
    vm = '{8'd4,  8'd2,  8'd5,  8'd13, 8'd5,   8'd1,  8'd11, 8'd0};
    vy = '{8'd20, 8'd20, 8'd20, 8'd20, 8'd100, 8'd1,  8'd0,  8'd5};
    for (int i = 0; i < 8; i++) begin
      commit(vd[i], vm[i], vy[i]);
      for (int c = 1; c <= 5; c++) begin
        @(negedge clk);
        checks++; if (bus.cs_n !== 1'b1) begin failures++; $display("FAIL inv_cs_n vec=%0d cycle=%0d got=%b exp=1", i, c, bus.cs_n); end
        checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL inv_done vec=%0d cycle=%0d got=%b exp=0", i, c, bus.done); end
        checks++; if (bus.error !== (c == 2)) begin failures++; $display("FAIL inv_error vec=%0d cycle=%0d got=%b exp=%b", i, c, bus.error, (c == 2)); end
        checks++; if (bus.busy !== (c == 1)) begin failures++; $display("FAIL inv_busy vec=%0d cycle=%0d got=%b exp=%b", i, c, bus.busy, (c == 1)); end
      end
    end
  endtask

  task automatic test_valid_boundary();
    logic [7:0] vd [3];
    logic [7:0] vm [3];
    logic [7:0] vy [3];
    logic [7:0] bd [3];
    logic [7:0] bm [3];
    logic [7:0] by [3];
    vd = '{8'd29, 8'd31, 8'd30};  bd = '{8'h29, 8'h31, 8'h30};
    vm = '{8'd2,  8'd12, 8'd4};   bm = '{8'h02, 8'h12, 8'h04};
    vy = '{8'd20, 8'd99, 8'd0};   by = '{8'h20, 8'h99, 8'h00};
    for (int i = 0; i < 3; i++) begin
      commit(vd[i], vm[i], vy[i]);
      for (int c = 1; c <= DONE_C + 1; c++) begin
        @(negedge clk);
        if (c == 2) begin
          checks++; if (bus.error !== 1'b0) begin failures++; $display("FAIL val_error vec=%0d got=%b exp=0", i, bus.error); end
          checks++; if (bus.cs_n !== 1'b0) begin failures++; $display("FAIL val_cs_n vec=%0d got=%b exp=0", i, bus.cs_n); end
          checks++; if (bus.ad_out !== 8'h24) begin failures++; $display("FAIL val_addr vec=%0d got=%h exp=24", i, bus.ad_out); end
        end
        if (c == 8) begin
          checks++; if (bus.ad_out !== bd[i]) begin failures++; $display("FAIL val_dia vec=%0d got=%h exp=%h", i, bus.ad_out, bd[i]); end
        end
        if (c == 20) begin
          checks++; if (bus.ad_out !== bm[i]) begin failures++; $display("FAIL val_mes vec=%0d got=%h exp=%h", i, bus.ad_out, bm[i]); end
        end
        if (c == 32) begin
          checks++; if (bus.ad_out !== by[i]) begin failures++; $display("FAIL val_year vec=%0d got=%h exp=%h", i, bus.ad_out, by[i]); end
        end
        if (c == DONE_C) begin
          checks++; if (bus.done !== 1'b1) begin failures++; $display("FAIL val_done vec=%0d got=%b exp=1", i, bus.done); end
        end
      end
    end
  endtask

  task automatic test_ignored_start();
    int ndone = 0;
    commit(8'd15, 8'd3, 8'd16);
    for (int c = 1; c <= DONE_C + 4; c++) begin
      @(negedge clk);
      if (bus.done === 1'b1) ndone++;
      if (c == 20) begin
        checks++; if (bus.ad_out !== 8'h03) begin failures++; $display("FAIL ign_mes got=%h exp=03", bus.ad_out); end
      end
      if (c == 32) begin
        checks++; if (bus.ad_out !== 8'h16) begin failures++; $display("FAIL ign_year got=%h exp=16", bus.ad_out); end
      end
      if (c == 10) begin
        bus.start = 1'b1; bus.dia_in = 8'd1; bus.mes_in = 8'd1; bus.year_in = 8'd1;
      end
      if (c == 11) bus.start = 1'b0;
    end
    checks++; if (ndone != 1) begin failures++; $display("FAIL ign_done_count got=%0d exp=1", ndone); end
  endtask

  task automatic test_fin_start();
    commit(8'd15, 8'd3, 8'd16);
    for (int c = 1; c <= DONE_C + 3; c++) begin
      @(negedge clk);
      if (c == DONE_C) begin
        checks++; if (bus.done !== 1'b1) begin failures++; $display("FAIL fin_done got=%b exp=1", bus.done); end
        bus.start = 1'b1; bus.dia_in = 8'd1; bus.mes_in = 8'd1; bus.year_in = 8'd1;
      end
      if (c == DONE_C + 1) begin
        bus.start = 1'b0;
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL fin_start_busy got=%b exp=0", bus.busy); end
      end
      if (c == DONE_C + 3) begin
        checks++; if (bus.cs_n !== 1'b1) begin failures++; $display("FAIL fin_start_cs_n got=%b exp=1", bus.cs_n); end
      end
    end
  endtask

  task automatic test_reset_mid();
    int ndone = 0;
    commit(8'd15, 8'd3, 8'd16);
    for (int c = 1; c <= 20; c++) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++; if (bus.cs_n !== 1'b1) begin failures++; $display("FAIL mid_cs_n got=%b exp=1", bus.cs_n); end
    checks++; if (bus.wr_n !== 1'b1) begin failures++; $display("FAIL mid_wr_n got=%b exp=1", bus.wr_n); end
    checks++; if (bus.ad_oe !== 1'b0) begin failures++; $display("FAIL mid_ad_oe got=%b exp=0", bus.ad_oe); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL mid_busy got=%b exp=0", bus.busy); end
    reset = 1'b0;
    for (int c = 0; c < 45; c++) begin
      @(negedge clk);
      if (bus.done === 1'b1 || bus.error === 1'b1) ndone++;
    end
    checks++; if (ndone != 0) begin failures++; $display("FAIL mid_no_done got=%0d exp=0", ndone); end
    commit(8'd31, 8'd12, 8'd99);
    for (int c = 1; c <= DONE_C; c++) begin
      @(negedge clk);
      if (c == 8) begin
        checks++; if (bus.ad_out !== 8'h31) begin failures++; $display("FAIL mid_restart_dia got=%h exp=31", bus.ad_out); end
      end
      if (c == DONE_C) begin
        checks++; if (bus.done !== 1'b1) begin failures++; $display("FAIL mid_restart_done got=%b exp=1", bus.done); end
      end
    end
  endtask

  initial begin
    bus.start   = 1'b0;
    bus.dia_in  = 8'd0;
    bus.mes_in  = 8'd0;
    bus.year_in = 8'd0;
    test_reset();
    test_write_sequence();
    test_invalid();
    test_valid_boundary();
    test_ignored_start();
    test_fin_start();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
